serial_add_arbiter: RTL
=======================

Name: serial_add_arbiter

Overview:
Shares one serial_adder among N requesters using round-robin arbitration. The block latches the winner's operands, pulses the adder's strt, and waits a fixed adder latency. It then captures the adder's sum and returns it to the winner with a one-cycle done pulse tagged with the requester ID. It sits between the client blocks and the single serial_adder instance.

Parameters:
W, 8, operand width; the adder sum is W+1 bits
N, 4, number of requesters (2..8)
ADD_LAT, 9, cycles from the adder sampling strt=1 to a valid, stable sum

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
req  in  N  per-requester request; held high until that requester's gnt
a_in  in  N*W  operand A, slice i*W +: W for requester i
b_in  in  N*W  operand B, same slicing
gnt  out  N  one-hot, one-cycle pulse; operands of that requester latched
busy  out  1  high from grant until done inclusive
done  out  1  one-cycle pulse; result and done_id valid
done_id  out  clog2(N)  index of the requester the result belongs to
result  out  W+1  captured sum
add_strt  out  1  to serial_adder strt
add_a  out  W  to serial_adder A; held stable for the whole operation
add_b  out  W  to serial_adder B; held stable for the whole operation
add_sum  in  W+1  from serial_adder sum

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous): state IDLE; gnt, busy, done, add_strt = 0; done_id, result, add_a, add_b = 0; count = 0; last grant pointer = N-1, so req[0] has top priority after reset.
- States: IDLE, RUN, DONE.
- IDLE, at an edge with any req[i]=1:
  - Pick the winner: first set bit scanning from last+1 upward, wrapping modulo N.
  - Latch that requester's a_in/b_in slices into add_a/add_b.
  - gnt[winner]=1, add_strt=1, busy=1, last=winner, count=ADD_LAT.
  - Go to RUN.
- In IDLE with no req, all pulses stay 0.
- RUN:
  - gnt and add_strt return to 0 after one cycle.
  - count decrements each edge.
  - At the edge where count==1: result<=add_sum, done<=1, done_id<=last; go to DONE.
  - Result is therefore sampled exactly ADD_LAT edges after the edge that first drove add_strt high.
- DONE: done, busy clear next edge; go to IDLE.
- Latency and throughput:
  - Request-sampling edge to done high: ADD_LAT cycles.
  - Next grant no earlier than ADD_LAT+2 edges after the previous grant.
- Requests during RUN/DONE are not granted and not lost while held. A req dropped before grant is simply forgotten.
- A requester that keeps req high after its gnt is re-arbitrated as a new operation at lowest priority.
- The block does not compute the sum; result = add_sum verbatim. Carry-out is result[W].
- add_a and add_b are never modified outside the IDLE->RUN grant edge.
- Reset mid-operation aborts the operation:
  - done never pulses for it.
  - add_strt drops immediately.
  - Arbitration restarts with req[0] priority.
- No X propagation: unselected a_in/b_in slices have no effect.

Test Plan:
1. Hold rst=0 with random req and add_sum -> gnt, busy, done, add_strt, result, add_a, add_b all 0. Release rst with req=0 -> no activity for 20 cycles.
2. req[0], A=0x33, B=0x55 (behavioural adder model, ADD_LAT=9) -> gnt=0001 and add_strt for one cycle; add_a=0x33, add_b=0x55; done 9 cycles later with result=0x088, done_id=0; busy high over 10 cycles.
3. req[2], A=0xB3, B=0xD5 -> gnt=0100; result=0x188 (carry set); done_id=2.
4. req=1111 held continuously -> grant order 0,1,2,3,0, grants spaced 11 cycles; each done_id matches its grant.
5. After the grant to 1, assert req[3] and req[1] together -> requester 3 is granted before 1. req[0] asserted mid-RUN waits, is then granted, and no result is lost.
6. Assert rst=0 during RUN (count=4) -> all outputs 0 immediately, no done for that operation. After release, with req=0110, requester 1 is granted first.

Source files
------------

// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter
//    Shares one serial_adder among N requesters with round-robin arbitration.
//    On a grant the winner's operands are latched onto add_a/add_b and
//    add_strt is pulsed. After ADD_LAT edges the adder sum is captured into
//    result, and done pulses for one cycle with done_id naming the requester.
//
// Ports
//    clk       in   rising-edge clock
//    rst       in   asynchronous reset, active low
//    req       in   [N]     per-requester request, held until its gnt
//    a_in      in   [N*W]   operand A, slice i*W +: W belongs to requester i
//    b_in      in   [N*W]   operand B, same slicing
//    gnt       out  [N]     one-hot, one-cycle grant pulse
//    busy      out          high from the grant until done, inclusive
//    done      out          one-cycle pulse; result/done_id valid
//    done_id   out  [IW]    requester index that owns result
//    result    out  [W+1]   captured adder sum (carry-out in result[W])
//    add_strt  out          start pulse to the serial_adder
//    add_a     out  [W]     operand A to the adder, stable for the operation
//    add_b     out  [W]     operand B to the adder, stable for the operation
//    add_sum   in   [W+1]   sum from the adder
module serial_add_arbiter #(
   parameter int W       = 8,
   parameter int N       = 4,
   parameter int ADD_LAT = 9,
   localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N*W-1:0]  a_in,
   input  logic [N*W-1:0]  b_in,
   output logic [N-1:0]    gnt,
   output logic            busy,
   output logic            done,
   output logic [IW-1:0]   done_id,
   output logic [W:0]      result,
   output logic            add_strt,
   output logic [W-1:0]    add_a,
   output logic [W-1:0]    add_b,
   input  logic [W:0]      add_sum
);

   localparam int CW = $clog2(ADD_LAT + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(ADD_LAT);
   localparam logic [IW-1:0] LAST_RST = IW'(N - 1);
   localparam logic [N-1:0]  GNT_ONE  = N'(1);

   logic [1:0]    state_q,   state_d;
   logic [N-1:0]  gnt_q,     gnt_d;
   logic          busy_q,    busy_d;
   logic          done_q,    done_d;
   logic [IW-1:0] done_id_q, done_id_d;
   logic [W:0]    result_q,  result_d;
   logic          strt_q,    strt_d;
   logic [W-1:0]  add_a_q,   add_a_d;
   logic [W-1:0]  add_b_q,   add_b_d;
   logic [IW-1:0] last_q,    last_d;
   logic [CW-1:0] count_q,   count_d;

   logic          win_found_s;
   logic [IW-1:0] win_idx_s;
   logic [IW-1:0] cand_s;

   // Round-robin pick: first requester found scanning upward from last+1, wrapping
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = {IW{1'b0}};
      cand_s      = {IW{1'b0}};
      for (int k = 1; k <= N; k++) begin
         cand_s = IW'((int'(last_q) + k) % N);
         if (!win_found_s && req[cand_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = cand_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Next-state logic for the IDLE -> RUN -> DONE operation sequence
   always_comb begin
      state_d   = state_q;
      gnt_d     = {N{1'b0}};
      strt_d    = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      result_d  = result_q;
      add_a_d   = add_a_q;
      add_b_d   = add_b_q;
      last_d    = last_q;
      count_d   = count_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found_s) begin
               // Only the winner's slices are read, so other slices may be X
               add_a_d = a_in[win_idx_s*W +: W];
               add_b_d = b_in[win_idx_s*W +: W];
               gnt_d   = GNT_ONE << win_idx_s;
               strt_d  = 1'b1;
               busy_d  = 1'b1;
               last_d  = win_idx_s;
               count_d = CNT_LOAD;
               state_d = ST_RUN;
            end else begin
               busy_d  = 1'b0;
            end
         end
         ST_RUN: begin
            count_d = count_q - CNT_ONE;
            // count reaches 1 on the ADD_LAT-th edge after the grant edge
            if (count_q == CNT_ONE) begin
               result_d  = add_sum;
               done_d    = 1'b1;
               done_id_d = last_q;
               state_d   = ST_DONE;
            end else begin
               state_d   = ST_RUN;
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         gnt_q     <= {N{1'b0}};
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= {IW{1'b0}};
         result_q  <= {(W+1){1'b0}};
         strt_q    <= 1'b0;
         add_a_q   <= {W{1'b0}};
         add_b_q   <= {W{1'b0}};
         last_q    <= LAST_RST;
         count_q   <= {CW{1'b0}};
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         result_q  <= result_d;
         strt_q    <= strt_d;
         add_a_q   <= add_a_d;
         add_b_q   <= add_b_d;
         last_q    <= last_d;
         count_q   <= count_d;
      end
   end

   assign gnt      = gnt_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign done_id  = done_id_q;
   assign result   = result_q;
   assign add_strt = strt_q;
   assign add_a    = add_a_q;
   assign add_b    = add_b_q;

endmodule
